serv_cdc_arb: RTL and testbench
===============================

# serv_cdc_arb

Source-domain arbiter sharing one two-phase CDC channel between `NUM_REQ` requesters. It sits in front of the CDC source half, on the same clock, and selects one requester per packet. Grant is round-robin and stays locked to a requester until that requester's `last` beat is accepted. Each beat is tagged with the requester ID and `last`, then held in an output register that drives the CDC `valid`/`data` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 32: payload width per beat.
- `ID_W`, `$clog2(NUM_REQ)`: requester tag width; derived, not overridden.
- `clk_i` in 1: source-domain clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NUM_REQ`: per-requester beat valid.
- `req_last_i` in `NUM_REQ`: per-requester last beat of packet.
- `req_data_i` in `NUM_REQ*DATA_W`: per-requester payload; requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready_o` out `NUM_REQ`: per-requester beat accepted.
- `cdc_valid_o` out 1: beat valid toward the CDC source `valid` input.
- `cdc_data_o` out `ID_W+1+DATA_W`: `{id, last, data}` toward the CDC source `data` input.
- `cdc_ready_i` in 1: CDC source `ready` output.
- `busy_o` out 1: FSM in LOCKED, or output register full.

## Operation
- **Output register (slot).** `slot_free = !cdc_valid_o || cdc_ready_i`.
- **FSM states.**
  - IDLE: no packet owner.
  - LOCKED: owner `gnt_q` mid-packet.
- **Arbitration in IDLE.**
  - When `slot_free` and any `req_valid_i` bit is set, pick the first valid requester starting at `ptr_q`, scanning upward with wrap.
  - Assert `req_ready_o[pick]`; all other ready bits stay 0.
  - Load the beat into the slot.
  - If `req_last_i[pick]`: stay in IDLE, `ptr_q <= pick+1` (mod `NUM_REQ`).
  - Otherwise: go to LOCKED, `gnt_q <= pick`.
- **LOCKED.**
  - Only `gnt_q` is eligible.
  - `req_ready_o[gnt_q] = slot_free && req_valid_i[gnt_q]`.
  - Others are never granted, even if `gnt_q` deasserts valid.
  - On an accepted beat with last: go to IDLE, `ptr_q <= gnt_q+1` (mod `NUM_REQ`).
- **Accept/drain in one cycle.** A slot drain (`cdc_valid_o && cdc_ready_i`) and a new load in the same cycle are allowed. This gives one beat per cycle when ready is held high.
- **Slot stability.** While `cdc_valid_o && !cdc_ready_i`, `cdc_data_o` is stable.
- **Modulo wrap.** `ptr_q` wraps from `NUM_REQ-1` to 0. The pick wraps modulo `NUM_REQ` for non-power-of-two counts.
- **Reset values.** All outputs 0. `ptr_q=0`, `gnt_q=0`, state IDLE.
- **Reset mid-packet.** Any in-flight slot content and lock are discarded. The CDC source half shares this reset.

## Timing
- `req_ready_o` is combinational from `req_valid_i`, state, `cdc_valid_o` and `cdc_ready_i`.
- Beat accepted in cycle N appears on `cdc_valid_o`/`cdc_data_o` in cycle N+1.
- `cdc_valid_o` and `cdc_data_o` are registered. There is no combinational path from inputs to them.
- `ptr_q` and state update on the acceptance edge.

## Configuration
- Macro: `SERV_CDC_ARB_PRIO_EN`.
- Defined:
  - In IDLE, requester 0 wins whenever `req_valid_i[0]` is set.
  - Otherwise round-robin among 1..`NUM_REQ`-1; `ptr_q` is never set to 0 for this scan.
  - Locking is unchanged; requester 0 does not preempt a LOCKED owner.
- Undefined: pure round-robin as above.

## Structure
- `serv_cdc_arb_pkg`:
  - FSM state enum `{IDLE, LOCKED}`.
  - Function `rr_next(idx, n)` returning `(idx+1) % n`.
  - Localparam limits `MAX_REQ=16`.
- Sub-module `serv_rr_pick`: combinational rotate-priority picker. Inputs: request vector, start pointer. Outputs: one-hot grant, index, any-valid.

## Test plan
- Reset with `req_valid_i=4'b1111`, all `last=1` → `cdc_valid_o=0`, `req_ready_o=0` during reset. After release, IDs appear in order 0,1,2,3,0 on consecutive cycles with `cdc_ready_i=1`.
- Req 2 sends 3-beat packet `0xA,0xB,0xC` (last on C) while req 0 and 1 are valid → output IDs 2,2,2 with data A,B,C. The next beat is ID 3 if valid, else 0. `req_ready_o[0]` and `[1]` stay 0 throughout.
- `cdc_ready_i=0` for 5 cycles with the slot full → `cdc_data_o` constant, all `req_ready_o=0`. Ready=1 → drain and reload in the same cycle.
- `NUM_REQ=3`, `ptr_q=2`, `req_valid_i=3'b011` → grant 0, then `ptr_q=1`.
- Assert `rst_ni=0` mid LOCKED packet → next cycle `cdc_valid_o=0`, state IDLE, `ptr_q=0`.
- With `SERV_CDC_ARB_PRIO_EN`: req 0 and req 3 continuously valid with `last=1` → output IDs 0,0,0… Req 0 drops → ID 3. Req 0 raised mid-LOCKED packet of req 1 → waits for req 1's last.

Source files
------------

// File: rtl/serv_cdc_arb_pkg.sv
// Shared types and helpers for the CDC channel arbiter.
// Optional build macro SERV_CDC_ARB_PRIO_EN is consumed by serv_cdc_arb.
package serv_cdc_arb_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1) % n;
  endfunction

endpackage

// File: rtl/serv_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above the
// start pointer, wrapping modulo N.
module serv_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    logic [IW-1:0] j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
  end

endmodule

// File: rtl/serv_cdc_arb.sv
// Packet-locked round-robin arbiter in front of a two-phase CDC source half.
// Define SERV_CDC_ARB_PRIO_EN to give requester 0 fixed priority in IDLE.
module serv_cdc_arb
  import serv_cdc_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      cdc_valid_o,
  output logic [ID_W+DATA_W:0]      cdc_data_o,
  input  logic                      cdc_ready_i,
  output logic                      busy_o
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_param
    $error("serv_cdc_arb: NUM_REQ out of range");
  end

  arb_state_e          r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gnt;
  logic                r_cdc_valid;
  logic [ID_W+DATA_W:0] r_cdc_data;

  logic [DATA_W-1:0]   w_req_data [NUM_REQ];
  logic [NUM_REQ-1:0]  w_pick_req;
  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_any;
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic [ID_W-1:0]     w_sel_idx;
  logic                w_sel_last;
  logic                w_slot_free;
  logic                w_accept;
  logic [ID_W-1:0]     w_next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_data[g] = req_data_i[g*DATA_W +: DATA_W];
  end

`ifdef SERV_CDC_ARB_PRIO_EN
  // Requester 0 is handled ahead of the rotating scan.
  assign w_pick_req = {req_valid_i[NUM_REQ-1:1], 1'b0};
`else
  assign w_pick_req = req_valid_i;
`endif

  serv_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .i_req (w_pick_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Candidate beat: locked owner only, otherwise the picker result.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = '0;
    if (r_state == LOCKED) begin
      w_sel_oh[r_gnt] = req_valid_i[r_gnt];
      w_sel_idx       = r_gnt;
    end
`ifdef SERV_CDC_ARB_PRIO_EN
    else if (req_valid_i[0]) begin
      w_sel_oh[0] = 1'b1;
    end
`endif
    else if (w_pick_any) begin
      w_sel_oh  = w_pick_gnt;
      w_sel_idx = w_pick_idx;
    end
  end

  always_comb begin
    w_next_ptr = ID_W'(rr_next(32'(w_sel_idx), NUM_REQ));
`ifdef SERV_CDC_ARB_PRIO_EN
    if (w_next_ptr == '0) w_next_ptr = ID_W'(1);
`endif
  end

  assign w_slot_free = !r_cdc_valid || cdc_ready_i;
  assign w_accept    = rst_ni && w_slot_free && (|w_sel_oh);
  assign w_sel_last  = req_last_i[w_sel_idx];
  assign req_ready_o = (rst_ni && w_slot_free) ? w_sel_oh : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cdc_valid <= 1'b0;
      r_cdc_data  <= '0;
    end else begin
      if (w_accept) begin
        r_cdc_valid <= 1'b1;
        r_cdc_data  <= {w_sel_idx, w_sel_last, w_req_data[w_sel_idx]};
      end else if (cdc_ready_i) begin
        r_cdc_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_sel_last) begin
              r_ptr <= w_next_ptr;
            end else begin
              r_state <= LOCKED;
              r_gnt   <= w_sel_idx;
            end
          end
        end
        LOCKED: begin
          if (w_accept && w_sel_last) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cdc_valid_o = r_cdc_valid;
  assign cdc_data_o  = r_cdc_data;
  assign busy_o      = (r_state == LOCKED) || r_cdc_valid;

endmodule

// File: tb/tb_serv_cdc_arb.sv
// Self-checking bench for serv_cdc_arb: directed vector table, corner
// sequences, and randomized traffic against a packet-level reference model.
module tb_serv_cdc_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int OW = IW + 1 + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid, last, ready;
  logic [N*DW-1:0] data;
  logic            cv, crdy, busy;
  logic [OW-1:0]   cdata;

  logic [2:0]  v3, l3, r3;
  logic [23:0] d3;
  logic        cv3, busy3;
  logic        c3 = 1'b1;
  logic [10:0] cd3;

  always #5 clk = ~clk;

  serv_cdc_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_last_i(last),
    .req_data_i(data), .req_ready_o(ready), .cdc_valid_o(cv),
    .cdc_data_o(cdata), .cdc_ready_i(crdy), .busy_o(busy)
  );

  serv_cdc_arb #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v3), .req_last_i(l3),
    .req_data_i(d3), .req_ready_o(r3), .cdc_valid_o(cv3),
    .cdc_data_o(cd3), .cdc_ready_i(c3), .busy_o(busy3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: packet owner, rotation pointer and one-deep output slot.
  bit            m_lock;
  int            m_gnt, m_ptr;
  bit            m_cv;
  logic [OW-1:0] m_data;

  function automatic void model_reset();
    m_lock = 0; m_gnt = 0; m_ptr = 0; m_cv = 0; m_data = '0;
  endfunction

  function automatic int model_pick();
    int sel = -1;
    if (m_cv && !crdy) return -1;
    if (m_lock) return valid[m_gnt] ? m_gnt : -1;
`ifdef SERV_CDC_ARB_PRIO_EN
    if (valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
`ifdef SERV_CDC_ARB_PRIO_EN
      if (j == 0) continue;
`endif
      if (sel < 0 && valid[j]) sel = j;
    end
    return sel;
  endfunction

  function automatic int next_ptr(input int s);
    int p = (s + 1) % N;
`ifdef SERV_CDC_ARB_PRIO_EN
    if (p == 0) p = 1;
`endif
    return p;
  endfunction

  function automatic void model_step(input int sel);
    if (sel >= 0) begin
      m_cv   = 1;
      m_data = {IW'(sel), last[sel], data[sel*DW +: DW]};
      if (last[sel]) begin
        m_lock = 0;
        m_ptr  = next_ptr(sel);
      end else begin
        m_lock = 1;
        m_gnt  = sel;
      end
    end else if (crdy) begin
      m_cv = 0;
    end
  endfunction

  task automatic cycle();
    logic [N-1:0] er;
    int sel;
    #2;
    sel = model_pick();
    er  = '0;
    if (sel >= 0) er[sel] = 1'b1;
    chk("ready", ready, er);
    @(posedge clk);
    model_step(sel);
    #1;
    chk("cdc_valid", cv, m_cv);
    if (m_cv) chk("cdc_data", cdata, m_data);
    chk("busy", busy, m_lock || m_cv);
  endtask

  typedef struct {
    logic [3:0] v, l;
    logic       r;
    logic [3:0] beat;
    logic [3:0] er;
    logic       ecv;
    logic [1:0] eid;
    logic       elast;
    logic [3:0] ebeat;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic [3:0] v, l, input logic r, input logic [3:0] beat,
                              input logic [3:0] er, input logic ecv, input logic [1:0] eid,
                              input logic elast, input logic [3:0] ebeat);
    vec_t t;
    t.v = v; t.l = l; t.r = r; t.beat = beat; t.er = er;
    t.ecv = ecv; t.eid = eid; t.elast = elast; t.ebeat = ebeat;
    return t;
  endfunction

  initial begin
`ifndef SERV_CDC_ARB_PRIO_EN
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      tab.push_back(mk(4'hF, 4'hF, 1, 4'(k + 1), oh, 1, 2'(k % 4), 1, 4'(k + 1)));
    end
    tab.push_back(mk(4'b0010, 4'b0010, 1, 4'h6, 4'b0010, 1, 2'd1, 1, 4'h6));
    tab.push_back(mk(4'b0111, 4'b0011, 1, 4'hA, 4'b0100, 1, 2'd2, 0, 4'hA));
    tab.push_back(mk(4'b0111, 4'b0011, 1, 4'hB, 4'b0100, 1, 2'd2, 0, 4'hB));
    tab.push_back(mk(4'b0011, 4'b0011, 1, 4'h5, 4'b0000, 0, 2'd0, 0, 4'h0));
    tab.push_back(mk(4'b0111, 4'b0111, 1, 4'hC, 4'b0100, 1, 2'd2, 1, 4'hC));
    tab.push_back(mk(4'b1011, 4'b1011, 1, 4'h6, 4'b1000, 1, 2'd3, 1, 4'h6));
    tab.push_back(mk(4'b0011, 4'b0011, 1, 4'h7, 4'b0001, 1, 2'd0, 1, 4'h7));
    tab.push_back(mk(4'hF, 4'hF, 1, 4'h8, 4'b0010, 1, 2'd1, 1, 4'h8));
    for (int k = 0; k < 5; k++)
      tab.push_back(mk(4'hF, 4'hF, 0, 4'h9, 4'b0000, 1, 2'd1, 1, 4'h8));
    tab.push_back(mk(4'hF, 4'hF, 1, 4'hA, 4'b0100, 1, 2'd2, 1, 4'hA));
    tab.push_back(mk(4'h0, 4'h0, 0, 4'h0, 4'b0000, 1, 2'd2, 1, 4'hA));
    tab.push_back(mk(4'h0, 4'h0, 1, 4'h0, 4'b0000, 0, 2'd0, 0, 4'h0));
`else
    for (int k = 0; k < 3; k++)
      tab.push_back(mk(4'b1001, 4'b1001, 1, 4'(k + 1), 4'b0001, 1, 2'd0, 1, 4'(k + 1)));
    tab.push_back(mk(4'b1000, 4'b1000, 1, 4'h4, 4'b1000, 1, 2'd3, 1, 4'h4));
    tab.push_back(mk(4'b0010, 4'b0000, 1, 4'h5, 4'b0010, 1, 2'd1, 0, 4'h5));
    tab.push_back(mk(4'b0011, 4'b0001, 1, 4'h6, 4'b0010, 1, 2'd1, 0, 4'h6));
    tab.push_back(mk(4'b0011, 4'b0011, 1, 4'h7, 4'b0010, 1, 2'd1, 1, 4'h7));
    tab.push_back(mk(4'b0011, 4'b0011, 1, 4'h8, 4'b0001, 1, 2'd0, 1, 4'h8));
`endif

    // Reset with every requester asking.
    rst_n = 1'b0; valid = 4'hF; last = 4'hF; crdy = 1'b1; data = '0;
    v3 = '0; l3 = '0; d3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cdc_valid", cv, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cdc_data", cdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[k]) begin
      valid = tab[k].v; last = tab[k].l; crdy = tab[k].r;
      for (int i = 0; i < N; i++) data[i*DW +: DW] = {4'(i), 24'h0, tab[k].beat};
      #1;
      chk($sformatf("tab%0d_ready", k), ready, tab[k].er);
      cycle();
      chk($sformatf("tab%0d_valid", k), cv, tab[k].ecv);
      if (tab[k].ecv)
        chk($sformatf("tab%0d_data", k), cdata,
            {tab[k].eid, tab[k].elast, 4'(tab[k].eid), 24'h0, tab[k].ebeat});
    end

    // Reset in the middle of a locked packet.
    valid = 4'b0100; last = 4'b0000; crdy = 1'b1;
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_cdc_valid", cv, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b0011; last = 4'b0011;
    cycle();
    chk("midrst_id", cdata[OW-1 -: IW], 0);

    // Three requesters: pointer at 2 wraps to requester 0.
    valid = '0;
    v3 = 3'b010; l3 = 3'b010;
    #1;
    chk("n3_first_ready", r3, 3'b010);
    @(posedge clk); #1;
    chk("n3_first_id", cd3[10:9], 2'd1);
    v3 = 3'b011; l3 = 3'b011;
    #1;
    chk("n3_wrap_ready", r3, 3'b001);
    @(posedge clk); #1;
    chk("n3_wrap_id", cd3[10:9], 2'd0);
    #1;
`ifndef SERV_CDC_ARB_PRIO_EN
    chk("n3_ptr1_ready", r3, 3'b010);
`else
    chk("n3_prio_ready", r3, 3'b001);
`endif
    v3 = '0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      valid = N'($urandom);
      last  = N'($urandom) | N'($urandom);
      crdy  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) data[i*DW +: DW] = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
